// File: rtl/ingress_pkt_arbiter.sv
// ingress_pkt_arbiter
// Shares one output word lane between NUM_PORTS input word streams. Each port has its
// own store-and-forward FIFO; whole packets are granted round-robin.
// Optional feature macro: ARB_STATS_EN (per-port 16-bit saturating drop counters).
module ingress_pkt_arbiter #(
  parameter int unsigned DATA_WIDTH    = 480,
  parameter int unsigned CTRL_WIDTH    = 32,
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned FIFO_AW       = 6,
  parameter int unsigned MAX_PKT_WORDS = 26
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_wr,
  input  logic [NUM_PORTS*CTRL_WIDTH-1:0] in_ctl,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic                            out_wr,
  output logic [CTRL_WIDTH-1:0]           out_ctl,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_PORTS)-1:0]    out_src,
  output logic [NUM_PORTS*16-1:0]         drop_cnt
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned WW    = CTRL_WIDTH + DATA_WIDTH;
  localparam int unsigned SW    = $clog2(NUM_PORTS);
  localparam int unsigned PW    = FIFO_AW + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [SW-1:0]        r_grant;
  logic [SW-1:0]        w_grant_nxt;
  logic [SW-1:0]        r_rr;
  logic [SW-1:0]        w_rr_nxt;
  logic                 w_pop;
  logic [WW-1:0]        w_rd_word;
  logic                 w_rd_eop;
  logic [NUM_PORTS-1:0] w_pkt_avail;
  logic [WW-1:0]        w_head [NUM_PORTS];

  logic                  r_out_wr;
  logic [CTRL_WIDTH-1:0] r_out_ctl;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SW-1:0]         r_out_src;

  // Word stored in FIFOs is {ctl, data}; ctl MSB is SOP, next bit is EOP.
  assign w_rd_word = w_head[r_grant];
  assign w_rd_eop  = w_rd_word[WW-2];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [CTRL_WIDTH-1:0] w_ctl;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_sop;
    logic                  w_eop;
    logic [PW-1:0]         w_free;
    logic                  w_room;
    logic                  w_wr_en;
    logic                  w_drop_sop;
    logic                  w_rd_en;
    logic                  w_cnt_inc;
    logic                  w_cnt_dec;

    logic [WW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_pkt_cnt;
    logic          r_in_pkt;
    logic          r_drop;

    assign w_ctl  = in_ctl[g*CTRL_WIDTH +: CTRL_WIDTH];
    assign w_data = in_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_sop  = w_ctl[CTRL_WIDTH-1];
    assign w_eop  = w_ctl[CTRL_WIDTH-2];
    assign w_free = PW'(DEPTH) - (r_wptr - r_rptr);
    // Admitting only with room for a worst-case packet keeps the FIFO from overflowing.
    assign w_room = (w_free >= PW'(MAX_PKT_WORDS));
    // Inside a packet every word is payload, even one carrying a stray SOP bit.
    assign w_wr_en    = in_wr[g] & (r_in_pkt | (~r_drop & w_sop & w_room));
    assign w_drop_sop = in_wr[g] & ~r_in_pkt & ~r_drop & w_sop & ~w_room;
    assign w_rd_en    = w_pop & (r_grant == SW'(g));
    assign w_cnt_inc  = w_wr_en & w_eop;
    assign w_cnt_dec  = w_rd_en & w_rd_eop;

    assign w_pkt_avail[g] = (r_pkt_cnt != '0);
    assign w_head[g]      = r_mem[r_rptr[FIFO_AW-1:0]];

    // FIFO storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
      if (w_wr_en) begin
        r_mem[r_wptr[FIFO_AW-1:0]] <= {w_ctl, w_data};
      end
    end

    // Pointers, packet framing flags and complete-packet count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_pkt_cnt <= '0;
        r_in_pkt  <= 1'b0;
        r_drop    <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wptr   <= r_wptr + PW'(1);
          r_in_pkt <= ~w_eop;
        end
        if (w_drop_sop) begin
          r_drop <= ~w_eop;
        end else if (in_wr[g] & r_drop & w_eop) begin
          r_drop <= 1'b0;
        end
        if (w_rd_en) begin
          r_rptr <= r_rptr + PW'(1);
        end
        // Simultaneous EOP write and EOP read cancel out.
        if (w_cnt_inc & ~w_cnt_dec) begin
          r_pkt_cnt <= r_pkt_cnt + PW'(1);
        end else if (w_cnt_dec & ~w_cnt_inc) begin
          r_pkt_cnt <= r_pkt_cnt - PW'(1);
        end
      end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of packets refused at admission.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_drop_cnt <= '0;
      end else if (w_drop_sop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end

    assign drop_cnt[g*16 +: 16] = r_drop_cnt;
`else
    assign drop_cnt[g*16 +: 16] = 16'h0000;
`endif
  end

  // Arbiter next state: pick next ready port after rr in IDLE, stream its packet in SEND.
  always_comb begin
    logic          found;
    int unsigned   idx;
    logic [SW-1:0] sel;
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr;
    w_pop       = 1'b0;
    found       = 1'b0;
    idx         = 0;
    sel         = '0;
    unique case (r_state)
      StIdle: begin
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
          idx = (32'(r_rr) + k) % NUM_PORTS;
          sel = SW'(idx);
          if (!found && w_pkt_avail[sel]) begin
            found       = 1'b1;
            w_grant_nxt = sel;
          end
        end
        if (found) begin
          w_state_nxt = StSend;
        end
      end
      StSend: begin
        w_pop = 1'b1;
        if (w_rd_eop) begin
          w_rr_nxt    = r_grant;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Arbiter state, grant and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_rr    <= SW'(NUM_PORTS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  // Registered output lane; ctl/data/src hold their last value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_wr   <= 1'b0;
      r_out_ctl  <= '0;
      r_out_data <= '0;
      r_out_src  <= '0;
    end else begin
      r_out_wr <= w_pop;
      if (w_pop) begin
        r_out_ctl  <= w_rd_word[WW-1 -: CTRL_WIDTH];
        r_out_data <= w_rd_word[DATA_WIDTH-1:0];
        r_out_src  <= r_grant;
      end
    end
  end

  assign out_wr   = r_out_wr;
  assign out_ctl  = r_out_ctl;
  assign out_data = r_out_data;
  assign out_src  = r_out_src;

endmodule

// File: tb/tb_ingress_pkt_arbiter.sv
// Directed bench for ingress_pkt_arbiter with a per-port scoreboard of expected words.
module tb_ingress_pkt_arbiter;

  localparam int DW = 480;
  localparam int CW = 32;
  localparam int NP = 4;
  localparam int WW = CW + DW;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     in_wr;
  logic [NP*CW-1:0]  in_ctl;
  logic [NP*DW-1:0]  in_data;
  logic              out_wr;
  logic [CW-1:0]     out_ctl;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_src;
  logic [NP*16-1:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [WW-1:0] exp_q [NP][$];
  int            exp_src_q [$];

  logic          prev_wr;
  logic          prev_eop;
  logic [WW-1:0] last_word;

  ingress_pkt_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .in_wr    (in_wr),
    .in_ctl   (in_ctl),
    .in_data  (in_data),
    .out_wr   (out_wr),
    .out_ctl  (out_ctl),
    .out_data (out_data),
    .out_src  (out_src),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int s;
    s = exp_src_q.size();
    for (int p = 0; p < NP; p++) s += exp_q[p].size();
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    in_wr = '0;
  endtask

  task automatic drive(input int p, input bit sop, input bit eop, input bit keep);
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    c = {sop, eop, 30'($urandom)};
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    in_wr[p]             = 1'b1;
    in_ctl[p*CW +: CW]   = c;
    in_data[p*DW +: DW]  = d;
    if (keep) exp_q[p].push_back({c, d});
  endtask

  task automatic send_pkt(input int p, input int n, input bit keep);
    for (int w = 0; w < n; w++) begin
      drive(p, w == 0, w == n - 1, keep);
      tick();
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int left;
    for (int i = 0; i < budget; i++) begin
      left = pending();
      if (left == 0 && !out_wr) break;
      tick();
    end
    left = pending();
    check(tag, WW'(left), WW'(0));
  endtask

  // Output monitor: framing, bit-exact words against the scoreboard, idle hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr   = 1'b0;
      prev_eop  = 1'b0;
      last_word = '0;
    end else begin
      if (prev_wr) check("out_wr_framing", WW'(out_wr), WW'(!prev_eop));
      if (out_wr) begin
        check("word_expected", WW'(exp_q[out_src].size() != 0), WW'(1));
        if (exp_q[out_src].size() != 0)
          check("word_data", {out_ctl, out_data}, exp_q[out_src].pop_front());
        if (out_ctl[CW-1] && exp_src_q.size() != 0)
          check("pkt_order", WW'(out_src), WW'(exp_src_q.pop_front()));
        prev_eop  = out_ctl[CW-2];
        last_word = {out_ctl, out_data};
      end else begin
        check("idle_hold", {out_ctl, out_data}, last_word);
      end
      prev_wr = out_wr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP*16-1:0] exp_drop;
    int seen;
    rst     = 1'b1;
    in_wr   = '0;
    in_ctl  = '0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_wr", WW'(out_wr), WW'(0));
    check("rst_out_ctl", WW'(out_ctl), WW'(0));
    check("rst_out_data", WW'(out_data), WW'(0));
    check("rst_out_src", WW'(out_src), WW'(0));
    check("rst_drop_cnt", WW'(drop_cnt), WW'(0));
    rst = 1'b0;
    tick();

    // 1: single 3-word packet on port 0, latency from EOP edge.
    send_pkt(0, 3, 1'b1);
    check("t1_lat_k", WW'(out_wr), WW'(0));
    tick();
    check("t1_lat_k1", WW'(out_wr), WW'(0));
    tick();
    check("t1_lat_k2", WW'(out_wr), WW'(1));
    check("t1_src", WW'(out_src), WW'(0));
    tick();
    check("t1_w1", WW'(out_wr), WW'(1));
    tick();
    check("t1_w2", WW'(out_wr), WW'(1));
    tick();
    check("t1_end", WW'(out_wr), WW'(0));
    wait_drain(50, "t1_drain");

    // Port 3 last served leaves the round-robin pointer at 3.
    send_pkt(3, 1, 1'b1);
    wait_drain(50, "pre2_drain");

    // 2: all ports hold a 2-word packet at once.
    for (int p = 0; p < NP; p++) exp_src_q.push_back(p);
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, 1'b1);
    tick();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b1, 1'b1);
    tick();
    wait_drain(100, "t2_drain");

    // 3: port 1 streams 26-word packets while port 0 competes; third port-1 packet dropped.
    exp_src_q.push_back(0);
    exp_src_q.push_back(1);
    exp_src_q.push_back(0);
    exp_src_q.push_back(1);
    for (int w = 0; w < 78; w++) begin
      if (w < 52) drive(0, (w % 26) == 0, (w % 26) == 25, 1'b1);
      drive(1, (w % 26) == 0, (w % 26) == 25, (w / 26) != 2);
      tick();
    end
    wait_drain(300, "t3_drain");
    exp_drop = '0;
`ifdef ARB_STATS_EN
    exp_drop[31:16] = 16'd1;
`endif
    check("t3_drop_cnt", WW'(drop_cnt), WW'(exp_drop));

    // 4: single-word packet on port 2 with a stray non-SOP word on port 3.
    drive(2, 1'b1, 1'b1, 1'b1);
    drive(3, 1'b0, 1'b0, 1'b0);
    tick();
    wait_drain(50, "t4_drain");
    check("t4_drop3", WW'(drop_cnt[63:48]), WW'(0));

    // 6: port 0 EOP written on the same edge an earlier EOP is read.
    send_pkt(0, 2, 1'b1);
    send_pkt(0, 3, 1'b1);
    check("t6_a_eop_out", WW'(out_wr), WW'(1));
    tick();
    check("t6_gap", WW'(out_wr), WW'(0));
    tick();
    check("t6_b_start", WW'(out_wr), WW'(1));
    wait_drain(50, "t6_drain");

    // 5: reset while sending word 4 of a 10-word packet; port 1 partial packet in flight.
    send_pkt(0, 10, 1'b1);
    tick();
    tick();
    drive(1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("t5_in_send", WW'(out_wr), WW'(1));
    rst = 1'b1;
    #1;
    check("t5_async_wr", WW'(out_wr), WW'(0));
    check("t5_async_data", {out_ctl, out_data}, WW'(0));
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    exp_src_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_drop_clr", WW'(drop_cnt), WW'(0));
    drive(1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1, 1'b0, 1'b1, 1'b0);
    tick();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_wr) seen++;
      tick();
    end
    check("t5_quiet", WW'(seen), WW'(0));
    send_pkt(2, 4, 1'b1);
    wait_drain(50, "t5_new_pkt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
